hdlc_tx_hub: RTL

HDLC_TX_HUB -- requirements
Module: hdlc_tx_hub

---
 rtl/hdlc_tx_hub_pkg.sv | 22 ++
 rtl/hdlc_tx_hub_chan.sv | 148 ++++++++++++++
 rtl/hdlc_tx_hub.sv | 98 +++++++++
 3 files changed

// File: rtl/hdlc_tx_hub_pkg.sv
// Shared constants for the HDLC transmit hub: register map, STATUS bit
// positions and the per-channel transmit FSM encoding.
package hdlc_tx_hub_pkg;

  localparam int unsigned REG_CTRL   = 0;
  localparam int unsigned REG_LEN    = 1;
  localparam int unsigned REG_STATUS = 2;
  localparam int unsigned REG_MASK   = 3;
  localparam int unsigned REG_CLR    = 4;

  localparam int unsigned ST_BUSY = 0;
  localparam int unsigned ST_DONE = 1;
  localparam int unsigned ST_OVR  = 2;

  typedef enum logic [1:0] {
    TX_IDLE    = 2'd0,
    TX_FETCH   = 2'd1,
    TX_PRESENT = 2'd2,
    TX_DONE    = 2'd3
  } tx_state_e;

endpackage

// File: rtl/hdlc_tx_hub_chan.sv
// One transmit channel: byte buffer, CTRL/LEN/STATUS/MASK/CLR registers and
// the frame FSM. HDLC_TX_HUB_IRQ_EN enables MASK and the channel interrupt.
module hdlc_tx_hub_chan
  import hdlc_tx_hub_pkg::*;
#(
  parameter int unsigned BUF_AW = 8
) (
  input  logic              clk_100m,
  input  logic              rst_n,
  input  logic              buf_we_i,
  input  logic              reg_we_i,
  input  logic [BUF_AW-1:0] off_i,
  input  logic [15:0]       wdata_i,
  output logic [7:0]        buf_rdata_o,
  output logic [15:0]       reg_rdata_o,
  output logic [7:0]        tx_byte_o,
  output logic              tx_sof_o,
  output logic              tx_eof_o,
  output logic              tx_valid_o,
  input  logic              tx_ready_i,
  output logic              irq_o
);

  localparam int unsigned     DEPTH   = 2 ** BUF_AW;
  localparam logic [BUF_AW:0] LEN_MAX = (BUF_AW + 1)'(DEPTH);

  logic [7:0]        mem_q [DEPTH];
  tx_state_e         state_q, state_d;
  logic [BUF_AW-1:0] idx_q, idx_d, last_q, last_d;
  logic [BUF_AW:0]   len_q, len_d;
  logic [7:0]        byte_q, byte_d;
  logic              done_q, done_d, ovr_q, ovr_d;
  logic [2:0]        mask_q;
  logic [2:0]        status;
  logic [31:0]       off_ext;
  logic              start, len_we, clr_we, busy, is_last;

  assign off_ext = 32'(off_i);
  assign start   = reg_we_i && (off_ext == REG_CTRL) && wdata_i[0];
  assign len_we  = reg_we_i && (off_ext == REG_LEN);
  assign clr_we  = reg_we_i && (off_ext == REG_CLR);
  assign busy    = (state_q != TX_IDLE);
  assign is_last = (idx_q == last_q);
  assign status  = {ovr_q, done_q, busy};

  // NOTE: the frame buffer has no reset; its contents survive rst_n by design.
  always_ff @(posedge clk_100m) begin
    if (buf_we_i) mem_q[off_i] <= wdata_i[7:0];
  end
  assign buf_rdata_o = mem_q[off_i];

  always_ff @(posedge clk_100m or negedge rst_n) begin
    if (!rst_n) state_q <= TX_IDLE;
    else        state_q <= state_d;
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      TX_IDLE:    if (start && len_q != '0) state_d = TX_FETCH;
      TX_FETCH:   state_d = TX_PRESENT;
      TX_PRESENT: if (tx_ready_i) state_d = is_last ? TX_DONE : TX_FETCH;
      TX_DONE:    state_d = TX_IDLE;
      default:    state_d = TX_IDLE;
    endcase
  end

  always_comb begin
    tx_valid_o = 1'b0;
    tx_sof_o   = 1'b0;
    tx_eof_o   = 1'b0;
    if (state_q == TX_PRESENT) begin
      tx_valid_o = 1'b1;
      tx_sof_o   = (idx_q == '0);
      tx_eof_o   = is_last;
    end
  end
  assign tx_byte_o = byte_q;

  // Set events are applied after CLR so a coincident set wins.
  always_comb begin
    idx_d  = idx_q;
    last_d = last_q;
    byte_d = byte_q;
    len_d  = len_q;
    done_d = done_q;
    ovr_d  = ovr_q;
    if (len_we) len_d = (32'(wdata_i) > DEPTH) ? LEN_MAX : wdata_i[BUF_AW:0];
    if (clr_we && wdata_i[ST_DONE]) done_d = 1'b0;
    if (clr_we && wdata_i[ST_OVR])  ovr_d  = 1'b0;
    case (state_q)
      TX_IDLE: if (start && len_q != '0) begin
        idx_d  = '0;
        last_d = BUF_AW'(len_q - 1'b1);
      end
      TX_FETCH:   byte_d = mem_q[idx_q];
      TX_PRESENT: if (tx_ready_i && !is_last) idx_d = idx_q + 1'b1;
      TX_DONE:    done_d = 1'b1;
      default: ;
    endcase
    if (start && busy) ovr_d = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk_100m or negedge rst_n) begin
    if (!rst_n) begin
      idx_q  <= '0;
      last_q <= '0;
      byte_q <= '0;
      len_q  <= '0;
      done_q <= 1'b0;
      ovr_q  <= 1'b0;
    end else begin
      idx_q  <= idx_d;
      last_q <= last_d;
      byte_q <= byte_d;
      len_q  <= len_d;
      done_q <= done_d;
      ovr_q  <= ovr_d;
    end
  end

`ifdef HDLC_TX_HUB_IRQ_EN
  logic mask_we;
  assign mask_we = reg_we_i && (off_ext == REG_MASK);

  always_ff @(posedge clk_100m or negedge rst_n) begin
    if (!rst_n)       mask_q <= '0;
    else if (mask_we) mask_q <= wdata_i[2:0];
  end
  assign irq_o = |(status[2:1] & mask_q[2:1]);
`else
  assign mask_q = '0;
  assign irq_o  = 1'b0;
`endif

  always_comb begin
    reg_rdata_o = '0;
    case (off_ext)
      REG_LEN:    reg_rdata_o = 16'(len_q);
      REG_STATUS: reg_rdata_o = {13'd0, status};
      REG_MASK:   reg_rdata_o = {13'd0, mask_q};
      default: ;
    endcase
  end

endmodule

// File: rtl/hdlc_tx_hub.sv
// HDLC transmit hub: EMIF address decode, registered read mux, shared bit
// clock and interrupt aggregation over NCH channel instances.
module hdlc_tx_hub
  import hdlc_tx_hub_pkg::*;
#(
  parameter int unsigned NCH     = 2,
  parameter int unsigned BUF_AW  = 8,
  parameter int unsigned CLK_DIV = 50
) (
  input  logic               clk_100m,
  input  logic               rst_n,
  input  logic               emif_wen,
  input  logic               emif_ren,
  input  logic [23:0]        emif_addr,
  input  logic [15:0]        emif_wdata,
  output logic [15:0]        emif_rdata,
  output logic               bit_clk,
  output logic [8*NCH-1:0]   tx_byte,
  output logic [NCH-1:0]     tx_sof,
  output logic [NCH-1:0]     tx_eof,
  output logic [NCH-1:0]     tx_valid,
  input  logic [NCH-1:0]     tx_ready,
  output logic               irq
);

  localparam int unsigned HALF  = CLK_DIV / 2;
  localparam int unsigned DIV_W = $clog2(CLK_DIV);

  logic [1:0]        ch_sel;
  logic              reg_region;
  logic [BUF_AW-1:0] off;
  logic [7:0]        buf_rdata [NCH];
  logic [15:0]       reg_rdata [NCH];
  logic [NCH-1:0]    chan_irq;
  logic [15:0]       rdata_d, rdata_q;
  logic [DIV_W-1:0]  div_q, div_d;
  logic              bit_clk_q, bit_clk_d;
  logic              unused_addr;

  assign ch_sel      = emif_addr[11:10];
  assign reg_region  = emif_addr[9];
  assign off         = emif_addr[BUF_AW-1:0];
  assign unused_addr = ^{emif_addr[23:12], emif_addr[8:0]};

  // Channel indices >= NCH match no instance: writes vanish and reads return 0.
  for (genvar g = 0; g < NCH; g++) begin : g_chan
    logic sel;
    assign sel = (ch_sel == 2'(g));

    hdlc_tx_hub_chan #(.BUF_AW(BUF_AW)) u_chan (
      .clk_100m    (clk_100m),
      .rst_n       (rst_n),
      .buf_we_i    (emif_wen && sel && !reg_region),
      .reg_we_i    (emif_wen && sel && reg_region),
      .off_i       (off),
      .wdata_i     (emif_wdata),
      .buf_rdata_o (buf_rdata[g]),
      .reg_rdata_o (reg_rdata[g]),
      .tx_byte_o   (tx_byte[8*g +: 8]),
      .tx_sof_o    (tx_sof[g]),
      .tx_eof_o    (tx_eof[g]),
      .tx_valid_o  (tx_valid[g]),
      .tx_ready_i  (tx_ready[g]),
      .irq_o       (chan_irq[g])
    );
  end

  always_comb begin
    rdata_d = '0;
    for (int i = 0; i < NCH; i++) begin
      if (ch_sel == 2'(i)) rdata_d = reg_region ? reg_rdata[i] : {8'h00, buf_rdata[i]};
    end
  end

  always_ff @(posedge clk_100m or negedge rst_n) begin
    if (!rst_n)        rdata_q <= '0;
    else if (emif_ren) rdata_q <= rdata_d;
  end
  assign emif_rdata = rdata_q;

  // Low while the divider sits in the first half of its count, high in the second.
  assign div_d     = (div_q == DIV_W'(CLK_DIV - 1)) ? '0 : div_q + 1'b1;
  assign bit_clk_d = (div_d >= DIV_W'(HALF));

  always_ff @(posedge clk_100m or negedge rst_n) begin
    if (!rst_n) begin
      div_q     <= '0;
      bit_clk_q <= 1'b0;
    end else begin
      div_q     <= div_d;
      bit_clk_q <= bit_clk_d;
    end
  end
  assign bit_clk = bit_clk_q;

  assign irq = |chan_irq;

endmodule
